// File: rtl/instruction_queue_if.sv
// rtl/instruction_queue_if.sv - fetch/dispatch side signals of the instruction queue
interface instruction_queue_if #(
    parameter int DEPTH    = 16,
    parameter int PTR_BITS = $clog2(DEPTH)
);
    logic                enqueue;
    logic [31:0]         enq_inst;
    logic [31:0]         enq_prog;
    logic                dequeue;
    logic                global_branch_signal;
    logic [31:0]         inst;
    logic [31:0]         prog;
    logic                is_iqueue_empty;
    logic                is_iqueue_full;
    logic [PTR_BITS:0]   count;

    modport master (
        output enqueue, enq_inst, enq_prog, dequeue, global_branch_signal,
        input  inst, prog, is_iqueue_empty, is_iqueue_full, count
    );

    modport slave (
        input  enqueue, enq_inst, enq_prog, dequeue, global_branch_signal,
        output inst, prog, is_iqueue_empty, is_iqueue_full, count
    );
endinterface

// File: rtl/instruction_queue.sv
// rtl/instruction_queue.sv - show-ahead circular FIFO between fetch and rename/dispatch
module instruction_queue #(
    parameter int DEPTH    = 16,
    parameter int PTR_BITS = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    instruction_queue_if.slave    iq
);
    localparam logic [PTR_BITS:0] PTR_ONE = {{PTR_BITS{1'b0}}, 1'b1};

    logic [PTR_BITS:0]   r_head;
    logic [PTR_BITS:0]   r_tail;
    logic [31:0]         r_inst_mem [DEPTH];
    logic [31:0]         r_prog_mem [DEPTH];

    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic [PTR_BITS-1:0] w_head_idx;
    logic [PTR_BITS-1:0] w_tail_idx;

    assign w_head_idx = r_head[PTR_BITS-1:0];
    assign w_tail_idx = r_tail[PTR_BITS-1:0];

    // Extra wrap bit distinguishes full from empty when the indices coincide.
    assign w_empty = (r_head == r_tail);
    assign w_full  = (w_head_idx == w_tail_idx) && (r_head[PTR_BITS] != r_tail[PTR_BITS]);

    // Push is gated by full only (not by a same-cycle pop) to keep dequeue off fetch's path.
    assign w_push = iq.enqueue && !w_full  && !iq.global_branch_signal;
    assign w_pop  = iq.dequeue && !w_empty && !iq.global_branch_signal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (iq.global_branch_signal) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_ONE;
            end
            if (w_pop) begin
                r_head <= r_head + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_inst_mem[w_tail_idx] <= iq.enq_inst;
            r_prog_mem[w_tail_idx] <= iq.enq_prog;
        end
    end

    assign iq.inst            = w_empty ? 32'h0 : r_inst_mem[w_head_idx];
    assign iq.prog            = w_empty ? 32'h0 : r_prog_mem[w_head_idx];
    assign iq.is_iqueue_empty = w_empty;
    assign iq.is_iqueue_full  = w_full;
    assign iq.count           = r_tail - r_head;
endmodule

// File: tb/tb_instruction_queue.sv
// tb/tb_instruction_queue.sv - directed vector bench for instruction_queue
module tb_instruction_queue;
    localparam int DEPTH = 16;

    typedef struct {
        logic        enq;
        logic [31:0] ei;
        logic [31:0] ep;
        logic        deq;
        logic        flush;
        logic [4:0]  cnt;
        logic        emp;
        logic        ful;
        logic [31:0] hi;
        logic [31:0] hp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    vec_t vecs[$];

    instruction_queue_if #(.DEPTH(DEPTH)) iq_if ();

    instruction_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .iq    (iq_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] v_inst(input int i);
        return 32'h0000_0013 + i;
    endfunction

    function automatic logic [31:0] v_prog(input int i);
        return 32'h6000_0004 + 4 * i;
    endfunction

    // hd < 0 means the queue is expected to be empty after the edge.
    function automatic vec_t mk(input bit enq, input int ei, input bit deq, input bit fl,
                                input int cnt, input int hd);
        vec_t v;
        v.enq   = enq;
        v.ei    = v_inst(ei);
        v.ep    = v_prog(ei);
        v.deq   = deq;
        v.flush = fl;
        v.cnt   = 5'(cnt);
        v.emp   = (cnt == 0);
        v.ful   = (cnt == DEPTH);
        v.hi    = (hd < 0) ? 32'h0 : v_inst(hd);
        v.hp    = (hd < 0) ? 32'h0 : v_prog(hd);
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [4:0] cnt, input logic emp,
                                 input logic ful, input logic [31:0] hi, input logic [31:0] hp);
        check({tag, "_count"}, 32'(iq_if.count), 32'(cnt));
        check({tag, "_empty"}, 32'(iq_if.is_iqueue_empty), 32'(emp));
        check({tag, "_full"},  32'(iq_if.is_iqueue_full), 32'(ful));
        check({tag, "_inst"},  iq_if.inst, hi);
        check({tag, "_prog"},  iq_if.prog, hp);
    endtask

    task automatic drive_idle();
        iq_if.enqueue              = 1'b0;
        iq_if.enq_inst             = 32'h0;
        iq_if.enq_prog             = 32'h0;
        iq_if.dequeue              = 1'b0;
        iq_if.global_branch_signal = 1'b0;
    endtask

    task automatic apply(input vec_t v, input string tag);
        iq_if.enqueue              = v.enq;
        iq_if.enq_inst             = v.ei;
        iq_if.enq_prog             = v.ep;
        iq_if.dequeue              = v.deq;
        iq_if.global_branch_signal = v.flush;
        @(posedge clk);
        #1;
        check_outputs(tag, v.cnt, v.emp, v.ful, v.hi, v.hp);
        drive_idle();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b1;
        drive_idle();

        for (int i = 0; i < 16; i++) vecs.push_back(mk(1, i, 0, 0, i + 1, 0));
        vecs.push_back(mk(1, 500, 0, 0, 16, 0));
        for (int k = 1; k <= 10; k++) vecs.push_back(mk(0, 0, 1, 0, 16 - k, k));
        for (int j = 0; j < 10; j++) vecs.push_back(mk(1, 16 + j, 0, 0, 7 + j, 10));
        for (int m = 1; m <= 16; m++) vecs.push_back(mk(0, 0, 1, 0, 16 - m, (m < 16) ? 10 + m : -1));
        vecs.push_back(mk(1, 100, 1, 0, 1, 100));
        vecs.push_back(mk(1, 101, 1, 0, 1, 101));
        for (int j = 0; j < 15; j++) vecs.push_back(mk(1, 102 + j, 0, 0, 2 + j, 101));
        vecs.push_back(mk(1, 600, 1, 0, 15, 102));
        for (int k = 1; k <= 8; k++) vecs.push_back(mk(0, 0, 1, 0, 15 - k, 102 + k));
        vecs.push_back(mk(1, 700, 1, 1, 0, -1));
        vecs.push_back(mk(0, 0, 1, 0, 0, -1));
        vecs.push_back(mk(1, 300, 0, 0, 1, 300));
        for (int j = 1; j <= 4; j++) vecs.push_back(mk(1, 300 + j, 0, 0, 1 + j, 300));

        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("reset", 5'd0, 1'b1, 1'b0, 32'h0, 32'h0);
        #20;
        rst_n = 1'b1;

        for (int n = 0; n < vecs.size(); n++) begin
            apply(vecs[n], $sformatf("vec%0d", n));
        end

        #3;
        rst_n = 1'b0;
        #1;
        check_outputs("midrst", 5'd0, 1'b1, 1'b0, 32'h0, 32'h0);
        #1;
        rst_n = 1'b1;

        iq_if.enqueue  = 1'b1;
        iq_if.enq_inst = 32'hDEAD_BEEF;
        iq_if.enq_prog = 32'h6000_0100;
        @(posedge clk);
        #1;
        drive_idle();
        check_outputs("postrst", 5'd1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h6000_0100);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
